// File: rtl/shift_seq.sv
// Multi-cycle barrel-free shifter: one bit per clock.
// Handles SLL/SRL/SRA/pass with abort and pipeline stall.
module shift_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        use_var,
  input  logic [4:0]  sa,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] wreg_q, wreg_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic [31:0] wreg_sh;
  logic        unused_rs;

  assign unused_rs = ^rs[31:5];

  always_comb begin
    wreg_sh = wreg_q;
    unique case (op_q)
      2'b00:   wreg_sh = {wreg_q[30:0], 1'b0};
      2'b01:   wreg_sh = {1'b0, wreg_q[31:1]};
      2'b10:   wreg_sh = {wreg_q[31], wreg_q[31:1]};
      default: wreg_sh = wreg_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wreg_d   = wreg_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            wreg_d  = rt;
            op_d    = op;
            state_d = SHIFT;
            if (op == 2'b11) cnt_d = 5'd0;
            else if (use_var) cnt_d = rs[4:0];
            else cnt_d = sa;
          end
        end
        SHIFT: begin
          if (cnt_q != 5'd0) begin
            wreg_d = wreg_sh;
            cnt_d  = cnt_q - 5'd1;
          end else begin
            result_d = wreg_q;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      wreg_q   <= 32'd0;
      op_q     <= 2'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wreg_q   <= wreg_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // stall is gated by reset so it reads 0 while rst_n is low
  assign stall  = rst_n &
                  (((state_q == IDLE) & start & ~flush) |
                   (state_q == SHIFT));
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Randomized bench for shift_seq against an
// arithmetic reference model.
module tb_shift_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic        use_var;
  logic [4:0]  sa;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  int n_checks;
  int n_errors;

  // model: phase 0 idle, 1 working, 2 done
  int          m_phase;
  int          m_age;
  int          m_need;
  logic [31:0] m_pend;
  logic [31:0] m_result;
  logic        m_done;

  shift_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .use_var (use_var),
    .sa      (sa),
    .rs      (rs),
    .rt      (rt),
    .flush   (flush),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(
    input logic [1:0] o, input int n,
    input logic [31:0] v);
    logic [31:0] r;
    case (o)
      2'b00:   r = v << n;
      2'b01:   r = v >> n;
      2'b10:   r = $signed(v) >>> n;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic int amount();
    if (op == 2'b11) return 0;
    if (use_var) return int'(rs[4:0]);
    return int'(sa);
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_age    = 0;
    m_need   = 0;
    m_pend   = '0;
    m_result = '0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      m_phase = 0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_age   = 0;
          m_need  = amount() + 1;
          m_pend  = ref_shift(op, amount(), rt);
        end
        1: begin
          m_age++;
          if (m_age == m_need) begin
            m_result = m_pend;
            m_done   = 1'b1;
            m_phase  = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  function automatic logic exp_stall();
    if (!rst_n) return 1'b0;
    return (m_phase == 0 && start && !flush) ||
           (m_phase == 1);
  endfunction

  // check outputs mid-cycle, then advance one edge
  task automatic cycle();
    @(negedge clk);
    check("result", result, m_result);
    check("done", 32'(done), 32'(m_done));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("stall", 32'(stall), 32'(exp_stall()));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    start = 0; flush = 0; op = 0; use_var = 0;
    sa = 0; rs = 0; rt = 0;
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic uv,
                        input logic [4:0] s,
                        input logic [31:0] r_s,
                        input logic [31:0] r_t,
                        input int n,
                        input logic [31:0] exp);
    int k;
    bit got;
    start = 1; flush = 0; op = o; use_var = uv;
    sa = s; rs = r_s; rt = r_t;
    cycle();
    start = 0;
    k = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      k++;
      if (done) begin
        got = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, k, n + 1);
    check({tag, "_result"}, result, exp);
    cycle();
  endtask

  initial begin
    logic [31:0] saved;
    bit seen_done;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    idle_in();
    rst_n = 0;
    #12;
    check("rst_result", result, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    start = 1;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    start = 0;
    @(posedge clk);
    #1;
    rst_n = 1;

    run_op("sll4", 2'b00, 0, 5'd4, 0, 32'h1, 4,
           32'h10);
    run_op("sra31", 2'b10, 0, 5'd31, 0,
           32'h8000_0000, 31, 32'hFFFF_FFFF);
    run_op("srlvar", 2'b01, 1, 5'd0, 32'hFFFF_FFE3,
           32'hF000_0000, 3, 32'h1E00_0000);
    run_op("pass", 2'b11, 0, 5'd7, 0,
           32'h1234_5678, 0, 32'h1234_5678);
    run_op("sll0", 2'b00, 0, 5'd0, 0,
           32'h1234_5678, 0, 32'h1234_5678);

    // flush and ignored start
    saved = result;
    start = 1; op = 0; use_var = 0; sa = 10;
    rt = 32'hA5A5_0001;
    cycle();
    start = 0;
    cycle();
    start = 1;
    cycle();
    start = 0;
    cycle();
    flush = 1;
    cycle();
    flush = 0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result", result, saved);
    run_op("after_flush", 2'b01, 0, 5'd2, 0,
           32'h80, 2, 32'h20);

    // reset mid-op
    start = 1; op = 0; use_var = 0; sa = 20;
    rt = 32'h3;
    cycle();
    start = 0;
    cycle();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    cycle();
    rst_n = 1;
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (done) seen_done = 1;
    end
    check("no_done_after_rst", 32'(seen_done), 32'd0);
    run_op("sll1", 2'b00, 0, 5'd1, 0, 32'h1, 1,
           32'h2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      op      = 2'($urandom);
      use_var = 1'($urandom);
      sa      = 5'($urandom);
      rs      = $urandom;
      rt      = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
